// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue between fetch/L1 I-cache and decode.
// Absorbs I-cache and decode stalls independently; flush empties it in one cycle.
module fetch_queue #(
  parameter int           n     = 32,
  parameter int           DEPTH = 4,
  parameter logic [n-1:0] NOP   = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         L1_busy,
  input  logic                         push_valid,
  input  logic [n-1:0]                 instruction_next,
  input  logic [n-1:0]                 pc_next,
  input  logic [n-1:0]                 pc_plus_four_next,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         full,
  output logic                         valid,
  output logic [n-1:0]                 instruction,
  output logic [n-1:0]                 pc,
  output logic [n-1:0]                 pc_plus_four,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [n-1:0] instruction;
    logic [n-1:0] pc;
    logic [n-1:0] pc_plus_four;
  } fq_entry_t;

  fq_entry_t     mem [DEPTH];
  fq_entry_t     wr_entry;
  fq_entry_t     head;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;

  assign full  = (cnt == CW'(DEPTH));
  assign valid = (cnt != '0);
  assign count = cnt;

  // Full blocks a push even if the head pops this cycle: no full-bypass.
  assign push = push_valid & ~L1_busy & ~full & ~flush;
  assign pop  = valid & ~stall & ~flush;

  assign wr_entry = '{
    instruction:  instruction_next,
    pc:           pc_next,
    pc_plus_four: pc_plus_four_next
  };

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      unique case (1'b1)
        push & ~pop: cnt <= cnt + CW'(1);
        pop & ~push: cnt <= cnt - CW'(1);
        default:     cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; stale slots are never visible past count.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wr_entry;
  end

  assign head = mem[rp];

  always_comb begin
    instruction  = NOP;
    pc           = '0;
    pc_plus_four = '0;
    if (valid) begin
      instruction  = head.instruction;
      pc           = head.pc;
      pc_plus_four = head.pc_plus_four;
    end
  end

endmodule
